// File: rtl/dmix_pkg.sv
// Shared constants for the dmix mixing datapath: sample/coefficient formats,
// saturation limits and the sequencer state encoding.
package dmix_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 15;

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 24'sh7FFFFF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 24'sh800000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/mix_sat.sv
// Combinational clamp of a widened signed accumulator to a 24-bit sample.
module mix_sat
    import dmix_pkg::*;
#(
    parameter int AW = 26
) (
    input  logic signed [AW-1:0]       acc_i,
    output logic        [SAMPLE_W-1:0] sample_o
);

    localparam logic signed [AW-1:0] MAX_W = AW'(SAMPLE_MAX);
    localparam logic signed [AW-1:0] MIN_W = AW'(SAMPLE_MIN);

    always_comb begin
        if (acc_i > MAX_W) begin
            sample_o = SAMPLE_MAX;
        end else if (acc_i < MIN_W) begin
            sample_o = SAMPLE_MIN;
        end else begin
            sample_o = acc_i[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/mixseq.sv
// Per-frame channel mix sequencer: latches NCH sample/volume pairs on a strobe,
// issues them to an external multiplier and accumulates the returning products.
module mixseq
    import dmix_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int MPLAT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    strobe_i,
    input  logic [SAMPLE_W*NCH-1:0] ch_data_i,
    input  logic [COEF_W*NCH-1:0]   vol_i,
    output logic [SAMPLE_W-1:0]     mpcand_o,
    output logic [COEF_W-1:0]       mplier_o,
    input  logic [SAMPLE_W-1:0]     mprod_i,
    output logic [SAMPLE_W-1:0]     mix_o,
    output logic                    mix_valid_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int AW   = SAMPLE_W + $clog2(NCH);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    logic [1:0]           state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [MPLAT:0]       tag_q, tag_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [SAMPLE_W-1:0]  mpcand_q, mpcand_d;
    logic [COEF_W-1:0]    mplier_q, mplier_d;
    logic [SAMPLE_W-1:0]  mix_q, mix_d;
    logic                 mix_valid_q, mix_valid_d;
    logic                 overrun_q, overrun_d;

    logic [SAMPLE_W-1:0]  data_q [NCH];
    logic [COEF_W-1:0]    vol_q  [NCH];

    logic                 drain_done;
    logic                 start;
    logic [IDXW-1:0]      idx_nxt;
    logic [SAMPLE_W-1:0]  sat_sample;

    mix_sat #(.AW(AW)) u_sat (
        .acc_i    (acc_q),
        .sample_o (sat_sample)
    );

    // The last product has been folded in once no tag is left in flight.
    assign drain_done = (state_q == ST_DRAIN) && (tag_q == '0);
    // A strobe on the finishing edge is taken, giving back-to-back frames.
    assign start      = strobe_i && ((state_q == ST_IDLE) || drain_done);
    assign idx_nxt    = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        mpcand_d    = '0;
        mplier_d    = '0;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        overrun_d   = 1'b0;

        tag_d[0] = (state_q == ST_ISSUE);
        for (int i = 1; i <= MPLAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (tag_q[MPLAT]) begin
            acc_d = acc_q + AW'($signed(mprod_i));
        end

        case (state_q)
            ST_ISSUE: begin
                overrun_d = strobe_i;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d    = idx_nxt;
                    mpcand_d = data_q[idx_nxt];
                    mplier_d = vol_q[idx_nxt];
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    mix_d       = sat_sample;
                    mix_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    overrun_d = strobe_i;
                end
            end
            default: ;
        endcase

        // Channel 0 comes straight from the inputs; the frame registers load on this edge.
        if (start) begin
            state_d  = ST_ISSUE;
            idx_d    = '0;
            acc_d    = '0;
            mpcand_d = ch_data_i[SAMPLE_W-1:0];
            mplier_d = vol_i[COEF_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= ch_data_i[SAMPLE_W*k +: SAMPLE_W];
                vol_q[k]  <= vol_i[COEF_W*k +: COEF_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            mpcand_q    <= '0;
            mplier_q    <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            mpcand_q    <= mpcand_d;
            mplier_q    <= mplier_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mpcand_o    = mpcand_q;
    assign mplier_o    = mplier_q;
    assign mix_o       = mix_q;
    assign mix_valid_o = mix_valid_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_mixseq.sv
// Self-checking bench for mixseq with an attached pipelined multiplier model
// and an expected-result queue filled when each frame is strobed.
module tb_mixseq;

    localparam int NCH   = 4;
    localparam int MPLAT = 4;
    localparam int LAT   = NCH + MPLAT + 2;

    logic            clk;
    logic            rst;
    logic            strobe;
    logic [24*NCH-1:0] ch_data;
    logic [16*NCH-1:0] vol;
    logic [23:0]     mpcand;
    logic [15:0]     mplier;
    logic [23:0]     mprod;
    logic [23:0]     mix;
    logic            mix_valid;
    logic            busy;
    logic            overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [23:0] exp_q [$];
    logic [23:0] fd [4];
    logic [15:0] fv [4];
    logic [23:0] mp [MPLAT+1];

    mixseq #(.NCH(NCH), .MPLAT(MPLAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .strobe_i    (strobe),
        .ch_data_i   (ch_data),
        .vol_i       (vol),
        .mpcand_o    (mpcand),
        .mplier_o    (mplier),
        .mprod_i     (mprod),
        .mix_o       (mix),
        .mix_valid_o (mix_valid),
        .busy_o      (busy),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mult(input logic [23:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 15;
        return p[23:0];
    endfunction

    // Multiplier: captures operands on an edge, product valid MPLAT edges later.
    always @(posedge clk) begin
        mp[0] <= mult(mpcand, mplier);
        for (int i = 1; i <= MPLAT; i++) mp[i] <= mp[i-1];
    end
    assign mprod = mp[MPLAT];

    function automatic logic [23:0] model_mix();
        longint sum;
        longint p;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            p = longint'($signed(fd[k])) * longint'($signed(fv[k]));
            sum += (p >>> 15);
        end
        if (sum > 64'sd8388607) sum = 64'sd8388607;
        if (sum < -64'sd8388608) sum = -64'sd8388608;
        return sum[23:0];
    endfunction

    task automatic start_frame();
        ch_data = {fd[3], fd[2], fd[1], fd[0]};
        vol     = {fv[3], fv[2], fv[1], fv[0]};
        exp_q.push_back(model_mix());
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int at, output logic [23:0] val);
        at  = -1;
        val = '0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (mix_valid) begin
                at  = n;
                val = mix;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe = 1'b0; ch_data = '1; vol = '1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if ({mpcand, mplier, mix, mix_valid, busy, overrun} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {mpcand, mplier, mix, mix_valid, busy, overrun});
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [23:0] held;
        held = '0;
        fd[0] = 24'sd1000; fd[1] = 24'sd2000; fd[2] = -24'sd500; fd[3] = 24'sd0;
        for (int k = 0; k < 4; k++) fv[k] = 16'h4000;
        start_frame();
        chk_cnt++;
        if (mpcand !== 24'd1000 || mplier !== 16'h4000 || busy !== 1'b1)
            $display("FAIL basic_issue0: got %h/%h busy %b want 0003e8/4000 busy 1", mpcand, mplier, busy);
        else pass_cnt++;
        for (int n = 1; n <= LAT + 1; n++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (busy !== (n < LAT) || mix_valid !== (n == LAT))
                $display("FAIL basic_timing cyc %0d: busy %b valid %b want %b %b", n, busy, mix_valid, n < LAT, n == LAT);
            else pass_cnt++;
            if (n == 2) begin
                chk_cnt++;
                if (mpcand !== 24'hFFFE0C) $display("FAIL basic_issue2: got %h want fffe0c", mpcand);
                else pass_cnt++;
            end
            if (n == NCH) begin
                chk_cnt++;
                if (mpcand !== '0 || mplier !== '0) $display("FAIL basic_opzero: got %h/%h want 0/0", mpcand, mplier);
                else pass_cnt++;
            end
            if (n == LAT) begin
                held = exp_q.pop_front();
                chk_cnt++;
                if (mix !== held || held !== 24'd1250) $display("FAIL basic_mix: got %0d want %0d", mix, held);
                else pass_cnt++;
            end
            if (n == LAT + 1) begin
                chk_cnt++;
                if (mix !== held) $display("FAIL basic_hold: got %0d want %0d", mix, held);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturation();
        int at;
        logic [23:0] val, exp;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                fd[k] = (c == 0) ? 24'h7FFFFF : 24'h800000;
                fv[k] = 16'h7FFF;
            end
            start_frame();
            wait_valid(LAT + 3, at, val);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
            chk_cnt++;
            if (at != LAT || val !== exp || val !== ((c == 0) ? 24'h7FFFFF : 24'h800000))
                $display("FAIL sat_%0d: got %h at %0d want %h at %0d", c, val, at, exp, LAT);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        int n_ovr, n_val;
        logic [23:0] exp;
        n_ovr = 0; n_val = 0;
        fd[0] = 24'sd3000; fd[1] = -24'sd1000; fd[2] = 24'sd7; fd[3] = 24'sd0;
        for (int k = 0; k < 4; k++) fv[k] = 16'h7FFF;
        start_frame();
        repeat (2) @(posedge clk);
        #1;
        ch_data = {4{24'h123456}};
        vol     = {4{16'h7FFF}};
        strobe  = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        chk_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", overrun);
        else pass_cnt++;
        for (int n = 4; n <= LAT + 5; n++) begin
            @(posedge clk); #1;
            if (overrun) n_ovr++;
            if (mix_valid) begin
                n_val++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
                chk_cnt++;
                if (mix !== exp || n != LAT) $display("FAIL overrun_mix: got %0d at %0d want %0d at %0d", mix, n, exp, LAT);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (n_ovr != 0 || n_val != 1) $display("FAIL overrun_counts: extra ovr %0d valid %0d want 0 1", n_ovr, n_val);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int at;
        logic [23:0] val, exp;
        fd[0] = 24'sd1000; fd[1] = 24'sd2000; fd[2] = -24'sd500; fd[3] = 24'sd0;
        for (int k = 0; k < 4; k++) fv[k] = 16'h4000;
        start_frame();
        repeat (LAT - 1) @(posedge clk);
        #1;
        fd[0] = 24'sd100; fd[1] = 24'sd0; fd[2] = 24'sd0; fd[3] = 24'sd0;
        for (int k = 0; k < 4; k++) fv[k] = 16'h7FFF;
        start_frame();
        exp = exp_q.pop_front();
        chk_cnt++;
        if (mix_valid !== 1'b1 || mix !== exp || overrun !== 1'b0)
            $display("FAIL b2b_first: got valid %b mix %0d ovr %b want 1 %0d 0", mix_valid, mix, overrun, exp);
        else pass_cnt++;
        wait_valid(LAT + 3, at, val);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
        chk_cnt++;
        if (at != LAT || val !== exp || val !== 24'd99)
            $display("FAIL b2b_second: got %0d at %0d want %0d at %0d", val, at, exp, LAT);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int at, n_val;
        logic [23:0] val, exp;
        n_val = 0;
        fd[0] = 24'sd1000; fd[1] = 24'sd2000; fd[2] = -24'sd500; fd[3] = 24'sd0;
        for (int k = 0; k < 4; k++) fv[k] = 16'h4000;
        start_frame();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk_cnt++;
        if ({mpcand, mplier, mix, mix_valid, busy, overrun} !== '0)
            $display("FAIL midreset_outputs: got %h want 0", {mpcand, mplier, mix, mix_valid, busy, overrun});
        else pass_cnt++;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (mix_valid) n_val++;
        end
        chk_cnt++;
        if (n_val != 0) $display("FAIL midreset_novalid: got %0d pulses want 0", n_val);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) fd[k] = -24'sd4000000;
        fd[3] = 24'sd12345;
        for (int k = 0; k < 4; k++) fv[k] = 16'h7FFF;
        start_frame();
        wait_valid(LAT + 3, at, val);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
        chk_cnt++;
        if (at != LAT || val !== exp) $display("FAIL midreset_next: got %h at %0d want %h at %0d", val, at, exp, LAT);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int at;
        logic [23:0] val, exp;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 4; k++) begin
                fd[k] = 24'($urandom_range(0, 24'hFFFFFF));
                fv[k] = 16'($urandom_range(0, 16'hFFFF));
            end
            start_frame();
            wait_valid(LAT + 3, at, val);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
            chk_cnt++;
            if (at != LAT || val !== exp) $display("FAIL random_%0d: got %h at %0d want %h at %0d", f, val, at, exp, LAT);
            else pass_cnt++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; ch_data = '0; vol = '0;
        for (int i = 0; i <= MPLAT; i++) mp[i] = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_random();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mixseq.md
# mixseq

Per-frame channel mix sequencer for the dmix datapath. Latches one 24-bit sample and one Q1.15 volume per channel on a frame strobe. Feeds the pairs one per cycle into the shared 24×16 multiplier (fixed pipeline latency `MPLAT`). Collects the returning products in a widened accumulator and emits one saturated 24-bit mixed sample per frame to the output stage.

## Interface
Parameters:
- `NCH`, default 4: number of channels mixed per frame (≥1).
- `MPLAT`, default 4: multiplier latency, in edges from operand capture to product valid.

Ports:
- `clk` in, 1: system clock; all logic on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `strobe_i` in, 1: frame start. Sampled every edge; accepted only when idle.
- `ch_data_i` in, 24*NCH: signed channel samples; channel k at bits [24k+23:24k].
- `vol_i` in, 16*NCH: signed Q1.15 volumes; channel k at bits [16k+15:16k].
- `mpcand_o` out, 24: multiplicand to the multiplier (registered).
- `mplier_o` out, 16: multiplier operand (registered).
- `mprod_i` in, 24: signed product from the multiplier, equal to (mpcand*mplier)>>>15.
- `mix_o` out, 24: signed saturated mix result (registered, held until next result).
- `mix_valid_o` out, 1: one-cycle pulse when `mix_o` updates.
- `busy_o` out, 1: high whenever not IDLE.
- `overrun_o` out, 1: one-cycle pulse when a strobe arrives while busy.

## Operation
- States: IDLE → ISSUE → DRAIN → IDLE.
- **IDLE, strobe_i=1:**
  - latch all `ch_data_i` and `vol_i` into frame registers;
  - clear the accumulator;
  - set issue index to 0;
  - go to ISSUE.
- **ISSUE:** drive channel `idx` onto `mpcand_o`/`mplier_o` for one cycle each, idx 0..NCH-1. After idx NCH-1, go to DRAIN.
- **Slot tracking:** a tag shift register of depth MPLAT+1 marks issued slots. When a tag emerges, `mprod_i` is sign-extended and added to the accumulator.
- **DRAIN:** wait for the last tag. Then:
  - saturate the accumulator into `mix_o`;
  - pulse `mix_valid_o`;
  - return to IDLE on the same edge.
- **Accumulator:** width 24+clog2(NCH), signed, so it cannot wrap.
- **Saturation:** clamp to [-8388608, +8388607].
- Outside ISSUE, `mpcand_o` and `mplier_o` are driven to 0.
- **Strobe while busy:** ignored. It does not restart or corrupt the frame; `overrun_o` pulses.
- **Reset** (any state, including mid-frame): state IDLE, all tags cleared, accumulator 0. All outputs (`mpcand_o`, `mplier_o`, `mix_o`, `mix_valid_o`, `busy_o`, `overrun_o`) = 0. An aborted frame produces no `mix_valid_o`.

## Timing
- Strobe accepted at edge E0.
- Channel k is present on the operand outputs in the cycle after E(k), and the multiplier captures it at E(k+1).
- `mprod_i` for channel k is valid after E(k+1+MPLAT) and is accumulated at E(k+2+MPLAT).
- Result: `mix_o`/`mix_valid_o` update at E(NCH+MPLAT+2); with defaults, at E10, valid during cycle 10.
- `busy_o` is high from after E0 until E(NCH+MPLAT+2), where it falls together with the `mix_valid_o` rise.
- A strobe sampled at E(NCH+MPLAT+2) is accepted (state is IDLE at that edge).
- Minimum frame period: NCH+MPLAT+2 cycles.
- `mix_o` holds its value between frames.

## Structure
- Shared package/header `dmix_pkg`:
  - sample width 24, coefficient width 16, coefficient fraction bits 15;
  - SAMPLE_MAX/SAMPLE_MIN constants;
  - state encoding for IDLE/ISSUE/DRAIN.
- One sub-module, `mix_sat`: combinational clamp from the widened accumulator to 24 bits, reused by later mix stages.
- Multiplier stays external; the block connects directly to it.

## Test plan
- **Basic mix** (NCH=4, MPLAT=4, multiplier model attached): samples {1000, 2000, -500, 0}, volumes all 0x4000, strobe → `mix_o`=1250, one-cycle `mix_valid_o` exactly 10 cycles after the strobe edge, `busy_o` high for cycles 1..9.
- **Positive saturation:** all samples 0x7FFFFF, volumes 0x7FFF → each product 8388351, `mix_o`=0x7FFFFF.
- **Negative saturation:** all samples 0x800000, volumes 0x7FFF → each product -8388352, `mix_o`=0x800000.
- **Overrun:** second strobe 3 cycles after the first → `overrun_o` pulses once; result equals the first frame's mix, unchanged; only one `mix_valid_o`.
- **Back-to-back frames:** second strobe on the `mix_valid_o` edge with new inputs {100, 0, 0, 0}, vol 0x7FFF → accepted; second `mix_o`=99, 10 cycles later.
- **Mid-frame reset:** `rst` asserted 5 cycles after a strobe → all outputs 0 next cycle, no `mix_valid_o`; a subsequent frame produces the correct result.
